// File: rtl/button_debouncer_if.sv
// Debouncer channel bundle: raw inputs and sample strobe in, clean levels and busy flags out.
// The master modport drives the raw lines; the slave modport is the debouncer itself.
interface button_debouncer_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0] async_in;
    logic            tick_en;
    logic [N_CH-1:0] clean;
    logic [N_CH-1:0] busy;

    modport master (
        output async_in,
        output tick_en,
        input  clean,
        input  busy
    );

    modport slave (
        input  async_in,
        input  tick_en,
        output clean,
        output busy
    );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel debouncer: 2-flop synchroniser then a per-channel stability-counter FSM.
// Latency: clean follows a held step STABLE_TICKS strobes after WAIT entry (7 clocks at defaults); no backpressure.
// Outputs are flop-driven: clean and busy are bits of the registered state encoding.
module button_debouncer #(
    parameter int N_CH         = 4,
    parameter int STABLE_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    button_debouncer_if.slave   bus
);
    localparam int CNT_W = $clog2(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // Encoding chosen so state[1] is the clean level and state[0] marks a qualification in progress.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    logic [N_CH-1:0] sync_s1;
    logic [N_CH-1:0] sync_s2;
    logic [N_CH-1:0] clean_vec;
    logic [N_CH-1:0] busy_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= bus.async_in;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t            state_q;
        state_t            state_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE_LOW;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // The level check comes before the count check, so a reversal on the completing strobe still rejects.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE_LOW: begin
                    if (sync_s2[i]) begin
                        state_d = WAIT_HIGH;
                        cnt_d   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (bus.tick_en) begin
                        if (!sync_s2[i]) begin
                            state_d = IDLE_LOW;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = IDLE_HIGH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_s2[i]) begin
                        state_d = WAIT_LOW;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOW: begin
                    if (bus.tick_en) begin
                        if (sync_s2[i]) begin
                            state_d = IDLE_HIGH;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = IDLE_LOW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
            endcase
        end

        assign clean_vec[i] = state_q[1];
        assign busy_vec[i]  = state_q[0];
    end

    assign bus.clean = clean_vec;
    assign bus.busy  = busy_vec;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: reset, qualification timing, bounce rejection, strobe gating, parallel channels.
module tb_button_debouncer;
    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;

    button_debouncer_if #(.N_CH(4)) dbg_if ();

    button_debouncer #(.N_CH(4), .STABLE_TICKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dbg_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1ns so outputs are sampled away from the edge.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dbg_if.async_in = 4'hF;
        dbg_if.tick_en  = 1'b1;
        wait_edges(3);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0) $display("FAIL reset_clean: got %h want 0", dbg_if.clean);
        else pass_cnt++;
        chk_cnt++;
        if (dbg_if.busy !== 4'h0) $display("FAIL reset_busy: got %h want 0", dbg_if.busy);
        else pass_cnt++;
        rst = 1'b0;
        wait_edges(6);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0 || dbg_if.busy !== 4'hF)
            $display("FAIL reset_early: clean %h busy %h want clean 0 busy f", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
        wait_edges(1);
        chk_cnt++;
        if (dbg_if.clean !== 4'hF || dbg_if.busy !== 4'h0)
            $display("FAIL reset_requal: clean %h busy %h want clean f busy 0", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
    endtask

    task automatic test_clean_step();
        dbg_if.async_in = 4'h0;
        wait_edges(10);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0) $display("FAIL step_settle: got %h want 0", dbg_if.clean);
        else pass_cnt++;
        dbg_if.async_in[0] = 1'b1;
        wait_edges(2);
        chk_cnt++;
        if (dbg_if.busy[0] !== 1'b0) $display("FAIL step_busy_early: got %b want 0", dbg_if.busy[0]);
        else pass_cnt++;
        wait_edges(1);
        chk_cnt++;
        if (dbg_if.busy[0] !== 1'b1) $display("FAIL step_busy_on: got %b want 1", dbg_if.busy[0]);
        else pass_cnt++;
        wait_edges(3);
        chk_cnt++;
        if (dbg_if.clean[0] !== 1'b0) $display("FAIL step_clean_early: got %b want 0", dbg_if.clean[0]);
        else pass_cnt++;
        wait_edges(1);
        chk_cnt++;
        if (dbg_if.clean !== 4'h1 || dbg_if.busy !== 4'h0)
            $display("FAIL step_rise: clean %h busy %h want clean 1 busy 0", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
        // Falling edge goes through WAIT_LOW with the same timing.
        dbg_if.async_in[0] = 1'b0;
        wait_edges(3);
        chk_cnt++;
        if (dbg_if.busy[0] !== 1'b1 || dbg_if.clean[0] !== 1'b1)
            $display("FAIL fall_wait: clean %b busy %b want clean 1 busy 1", dbg_if.clean[0], dbg_if.busy[0]);
        else pass_cnt++;
        wait_edges(3);
        chk_cnt++;
        if (dbg_if.clean[0] !== 1'b1) $display("FAIL fall_clean_early: got %b want 1", dbg_if.clean[0]);
        else pass_cnt++;
        wait_edges(1);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0 || dbg_if.busy !== 4'h0)
            $display("FAIL fall_done: clean %h busy %h want 0 0", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
    endtask

    task automatic test_bounce_reject();
        for (int i = 0; i < 6; i++) begin
            dbg_if.async_in[1] = (i % 2 == 0);
            wait_edges(1);
            chk_cnt++;
            if (dbg_if.clean[1] !== 1'b0) $display("FAIL bounce_clean_%0d: got %b want 0", i, dbg_if.clean[1]);
            else pass_cnt++;
        end
        dbg_if.async_in[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_edges(1);
            chk_cnt++;
            if (dbg_if.clean[1] !== 1'b0) $display("FAIL bounce_hold_%0d: got %b want 0", i, dbg_if.clean[1]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (dbg_if.busy[1] !== 1'b0) $display("FAIL bounce_busy: got %b want 0", dbg_if.busy[1]);
        else pass_cnt++;
    endtask

    // High for exactly four clocks: the drop reaches s2 on the completing strobe, so it must reject.
    task automatic test_boundary_reject();
        dbg_if.async_in[0] = 1'b1;
        wait_edges(4);
        dbg_if.async_in[0] = 1'b0;
        wait_edges(3);
        chk_cnt++;
        if (dbg_if.clean[0] !== 1'b0 || dbg_if.busy[0] !== 1'b0)
            $display("FAIL boundary_reject: clean %b busy %b want 0 0", dbg_if.clean[0], dbg_if.busy[0]);
        else pass_cnt++;
        wait_edges(5);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0) $display("FAIL boundary_after: got %h want 0", dbg_if.clean);
        else pass_cnt++;
    endtask

    task automatic test_strobe_gating();
        dbg_if.tick_en = 1'b0;
        dbg_if.async_in[2] = 1'b1;
        wait_edges(4);
        chk_cnt++;
        if (dbg_if.busy[2] !== 1'b1 || dbg_if.clean[2] !== 1'b0)
            $display("FAIL gate_wait: clean %b busy %b want clean 0 busy 1", dbg_if.clean[2], dbg_if.busy[2]);
        else pass_cnt++;
        for (int s = 1; s <= 4; s++) begin
            wait_edges(9);
            chk_cnt++;
            if (dbg_if.clean[2] !== 1'b0) $display("FAIL gate_idle_%0d: got %b want 0", s, dbg_if.clean[2]);
            else pass_cnt++;
            dbg_if.tick_en = 1'b1;
            wait_edges(1);
            dbg_if.tick_en = 1'b0;
            chk_cnt++;
            if (dbg_if.clean[2] !== (s == 4))
                $display("FAIL gate_strobe_%0d: got %b want %b", s, dbg_if.clean[2], (s == 4));
            else pass_cnt++;
        end
        dbg_if.tick_en = 1'b1;
    endtask

    task automatic test_mid_reset();
        dbg_if.async_in = 4'h0;
        wait_edges(10);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0) $display("FAIL midrst_settle: got %h want 0", dbg_if.clean);
        else pass_cnt++;
        dbg_if.async_in[3] = 1'b1;
        wait_edges(5);
        chk_cnt++;
        if (dbg_if.busy[3] !== 1'b1) $display("FAIL midrst_wait: got %b want 1", dbg_if.busy[3]);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (dbg_if.clean !== 4'h0 || dbg_if.busy !== 4'h0)
            $display("FAIL midrst_async: clean %h busy %h want 0 0", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
        wait_edges(1);
        rst = 1'b0;
        wait_edges(6);
        chk_cnt++;
        if (dbg_if.clean[3] !== 1'b0) $display("FAIL midrst_early: got %b want 0", dbg_if.clean[3]);
        else pass_cnt++;
        wait_edges(1);
        chk_cnt++;
        if (dbg_if.clean !== 4'h8 || dbg_if.busy !== 4'h0)
            $display("FAIL midrst_requal: clean %h busy %h want 8 0", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
    endtask

    task automatic test_parallel();
        dbg_if.async_in = 4'h0;
        wait_edges(10);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0) $display("FAIL par_settle: got %h want 0", dbg_if.clean);
        else pass_cnt++;
        dbg_if.async_in = 4'h9;
        wait_edges(6);
        chk_cnt++;
        if (dbg_if.clean !== 4'h0 || dbg_if.busy !== 4'h9)
            $display("FAIL par_wait: clean %h busy %h want 0 9", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
        wait_edges(1);
        chk_cnt++;
        if (dbg_if.clean !== 4'h9 || dbg_if.busy !== 4'h0)
            $display("FAIL par_rise: clean %h busy %h want 9 0", dbg_if.clean, dbg_if.busy);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_clean_step();
        test_bounce_reject();
        test_boundary_reject();
        test_strobe_gating();
        test_mid_reset();
        test_parallel();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
